// File: rtl/puf_response_collector.sv
// -----------------------------------------------------------------------------
// puf_response_collector
//
// Sequences repeated evaluations of a 32-bit arbiter PUF for one challenge and
// reduces the samples to a majority-voted response plus a per-bit stability
// mask, handed downstream through a valid/ready handshake.
//
// Ports
//   clk          system clock
//   rst_n        synchronous active-low reset
//   start        request a run (accepted only while idle)
//   challenge_i  challenge, captured on an accepted start
//   challenge_o  latched challenge to the delay-line selects
//   launch_o     excitation edge into both delay lines (registered, glitch-free)
//   arb_q_i      arbiter bank outputs, asynchronous to clk
//   busy         high whenever a run or handshake is in progress
//   resp_valid   response available
//   resp_ready   consumer accepts the response
//   response_o   majority-voted response
//   stable_o     1 where every sample of that bit agreed
// -----------------------------------------------------------------------------
module puf_response_collector #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned CHAL_WIDTH    = 64,
    parameter int unsigned NUM_EVAL      = 16,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned REARM_CYCLES  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CHAL_WIDTH-1:0] challenge_i,
    output logic [CHAL_WIDTH-1:0] challenge_o,
    output logic                  launch_o,
    input  logic [DATA_WIDTH-1:0] arb_q_i,
    output logic                  busy,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] response_o,
    output logic [DATA_WIDTH-1:0] stable_o
);

    // Ones-counters hold 0..NUM_EVAL, so they can never wrap.
    localparam int unsigned OW   = $clog2(NUM_EVAL + 1);
    localparam int unsigned PMAX = (SETTLE_CYCLES > REARM_CYCLES) ? SETTLE_CYCLES : REARM_CYCLES;
    localparam int unsigned PW   = $clog2(PMAX);

    localparam logic [PW-1:0] SETTLE_LAST = PW'(SETTLE_CYCLES - 1);
    localparam logic [PW-1:0] REARM_LAST  = PW'(REARM_CYCLES - 1);
    localparam logic [OW-1:0] EVAL_FULL   = OW'(NUM_EVAL);
    localparam logic [OW-1:0] EVAL_HALF   = OW'(NUM_EVAL / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_SAMPLE,
        S_REARM,
        S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [PW-1:0]           phase_q, phase_d;
    logic [OW-1:0]           eval_q, eval_d;
    logic [OW-1:0]           ones_q [DATA_WIDTH];
    logic [OW-1:0]           ones_d [DATA_WIDTH];
    logic [DATA_WIDTH-1:0]   sync1_q, sync1_d;
    logic [DATA_WIDTH-1:0]   sync2_q, sync2_d;
    logic [CHAL_WIDTH-1:0]   challenge_q, challenge_d;
    logic [DATA_WIDTH-1:0]   response_q, response_d;
    logic [DATA_WIDTH-1:0]   stable_q, stable_d;
    logic                    launch_q, launch_d;

    always_comb begin
        // NOTE: every combinationally assigned signal gets a hold default first,
        // so no path through the case below can leave one unassigned (latch).
        state_d     = state_q;
        phase_d     = phase_q;
        eval_d      = eval_q;
        ones_d      = ones_q;
        challenge_d = challenge_q;
        response_d  = response_q;
        stable_d    = stable_q;

        // Two-stage synchroniser, always running; accumulation sees only sync2.
        sync1_d = arb_q_i;
        sync2_d = sync1_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    challenge_d = challenge_i;
                    eval_d      = '0;
                    ones_d      = '{default: '0};
                    phase_d     = '0;
                    state_d     = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (phase_q == SETTLE_LAST) begin
                    phase_d = '0;
                    state_d = S_SAMPLE;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            S_SAMPLE: begin
                for (int i = 0; i < DATA_WIDTH; i++) begin
                    if (sync2_q[i] && (ones_q[i] != EVAL_FULL)) begin
                        ones_d[i] = ones_q[i] + 1'b1;
                    end
                end
                if (eval_q != EVAL_FULL) begin
                    eval_d = eval_q + 1'b1;
                end
                state_d = S_REARM;
            end
            S_REARM: begin
                if (phase_q == REARM_LAST) begin
                    phase_d = '0;
                    if (eval_q == EVAL_FULL) begin
                        state_d = S_DONE;
                        // Strict majority: a tie on an even NUM_EVAL votes 0.
                        for (int i = 0; i < DATA_WIDTH; i++) begin
                            response_d[i] = (ones_q[i] > EVAL_HALF);
                            stable_d[i]   = (ones_q[i] == '0) || (ones_q[i] == EVAL_FULL);
                        end
                    end else begin
                        state_d = S_LAUNCH;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            S_DONE: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Registered from the next state so the delay lines see a clean edge.
        launch_d = (state_d == S_LAUNCH) || (state_d == S_SAMPLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            eval_q      <= '0;
            // NOTE: the ones-counter bank is reset explicitly (not left to the
            // next start) so an aborted run leaves no stale counts behind.
            ones_q      <= '{default: '0};
            sync1_q     <= '0;
            sync2_q     <= '0;
            challenge_q <= '0;
            response_q  <= '0;
            stable_q    <= '0;
            launch_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge
            // values; blocking here would chain sync1 straight into sync2.
            state_q     <= state_d;
            phase_q     <= phase_d;
            eval_q      <= eval_d;
            ones_q      <= ones_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            challenge_q <= challenge_d;
            response_q  <= response_d;
            stable_q    <= stable_d;
            launch_q    <= launch_d;
        end
    end

    assign challenge_o = challenge_q;
    assign launch_o    = launch_q;
    assign busy        = (state_q != S_IDLE);
    assign resp_valid  = (state_q == S_DONE);
    assign response_o  = response_q;
    assign stable_o    = stable_q;

endmodule

// File: tb/tb_puf_response_collector.sv
// -----------------------------------------------------------------------------
// tb_puf_response_collector
//
// Directed bench for puf_response_collector: one instance with default
// parameters and one in the minimum configuration (1 eval, settle 3, rearm 1).
// Inputs change and outputs are sampled on the falling edge; "cycle k" is the
// k-th falling edge after the rising edge that samples start.
// -----------------------------------------------------------------------------
module tb_puf_response_collector;

    logic        clk = 1'b0;
    logic        rst_n;

    // Default-parameter instance
    logic        start;
    logic [63:0] challenge_i;
    logic [63:0] challenge_o;
    logic        launch_o;
    logic [31:0] arb_q_i;
    logic        busy;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] response_o;
    logic [31:0] stable_o;

    // Minimum-configuration instance
    logic        m_start;
    logic [63:0] m_challenge_i;
    logic [63:0] m_challenge_o;
    logic        m_launch_o;
    logic [31:0] m_arb_q_i;
    logic        m_busy;
    logic        m_resp_valid;
    logic        m_resp_ready;
    logic [31:0] m_response_o;
    logic [31:0] m_stable_o;

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    always #5 clk = ~clk;

    puf_response_collector dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .challenge_i (challenge_i),
        .challenge_o (challenge_o),
        .launch_o    (launch_o),
        .arb_q_i     (arb_q_i),
        .busy        (busy),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .response_o  (response_o),
        .stable_o    (stable_o)
    );

    puf_response_collector #(
        .NUM_EVAL      (1),
        .SETTLE_CYCLES (3),
        .REARM_CYCLES  (1)
    ) dut_min (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (m_start),
        .challenge_i (m_challenge_i),
        .challenge_o (m_challenge_o),
        .launch_o    (m_launch_o),
        .arb_q_i     (m_arb_q_i),
        .busy        (m_busy),
        .resp_valid  (m_resp_valid),
        .resp_ready  (m_resp_ready),
        .response_o  (m_response_o),
        .stable_o    (m_stable_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue start in the current cycle; returns in cycle 1.
    task automatic start_run(input logic [63:0] chal);
        challenge_i = chal;
        start       = 1'b1;
        step();
        start       = 1'b0;
    endtask

    // One 17-cycle evaluation starting at its first LAUNCH cycle. Optionally
    // pulses start (with a different challenge) at offset start_j.
    task automatic run_eval(input logic [31:0] val, input int start_j, input logic [63:0] new_chal);
        arb_q_i = val;
        for (int j = 0; j < 17; j++) begin
            check("launch_o", 64'(launch_o), 64'(j < 9));
            check("resp_valid_low", 64'(resp_valid), 64'(0));
            if (j == start_j) begin
                start       = 1'b1;
                challenge_i = new_chal;
            end
            step();
            start = 1'b0;
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        challenge_i   = 64'h0;
        arb_q_i       = 32'h0;
        resp_ready    = 1'b1;
        m_start       = 1'b0;
        m_challenge_i = 64'h0;
        m_arb_q_i     = 32'h0000A5A5;
        m_resp_ready  = 1'b1;

        // ---- Reset state ----
        @(negedge clk);
        step();
        step();
        check("rst_launch", 64'(launch_o), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_valid", 64'(resp_valid), 64'(0));
        check("rst_response", 64'(response_o), 64'(0));
        check("rst_stable", 64'(stable_o), 64'(0));
        check("rst_challenge", challenge_o, 64'h0);
        check("rst_min_busy", 64'(m_busy), 64'(0));
        rst_n = 1'b1;
        step();

        // ---- Unanimous ones ----
        start_run(64'h0123_4567_89AB_CDEF);
        check("t1_busy", 64'(busy), 64'(1));
        for (int n = 0; n < 16; n++) run_eval(32'hFFFF_FFFF, -1, 64'h0);
        check("t1_valid", 64'(resp_valid), 64'(1));
        check("t1_response", 64'(response_o), 64'hFFFF_FFFF);
        check("t1_stable", 64'(stable_o), 64'hFFFF_FFFF);
        check("t1_challenge", challenge_o, 64'h0123_4567_89AB_CDEF);
        step();
        check("t1_valid_drop", 64'(resp_valid), 64'(0));
        check("t1_busy_drop", 64'(busy), 64'(0));

        // ---- Tie and majority, with start pulses while busy ----
        start_run(64'hAAAA_0000_5555_1111);
        for (int n = 0; n < 16; n++) begin
            // bit0 high on evals 0..7 (8 of 16), bit1 high on evals 0..8 (9 of 16)
            run_eval({30'b0, (n < 9), (n < 8)}, (n == 2) ? 15 : -1, 64'hDEAD_DEAD_DEAD_DEAD);
        end
        check("t2_valid", 64'(resp_valid), 64'(1));
        check("t2_response", 64'(response_o), 64'h0000_0002);
        check("t2_stable", 64'(stable_o), 64'hFFFF_FFFC);
        check("t2_challenge", challenge_o, 64'hAAAA_0000_5555_1111);
        start       = 1'b1;
        challenge_i = 64'hBEEF_BEEF_BEEF_BEEF;
        step();
        start = 1'b0;
        check("t2_busy_after_start_in_done", 64'(busy), 64'(0));
        check("t2_challenge_kept", challenge_o, 64'hAAAA_0000_5555_1111);

        // ---- Backpressure ----
        resp_ready = 1'b0;
        start_run(64'h1111_2222_3333_4444);
        for (int n = 0; n < 16; n++) run_eval(32'hDEAD_BEEF, -1, 64'h0);
        check("t3_valid", 64'(resp_valid), 64'(1));
        check("t3_response", 64'(response_o), 64'hDEAD_BEEF);
        check("t3_stable", 64'(stable_o), 64'hFFFF_FFFF);
        for (int k = 0; k < 20; k++) begin
            step();
            check("t3_hold_valid", 64'(resp_valid), 64'(1));
            check("t3_hold_response", 64'(response_o), 64'hDEAD_BEEF);
            check("t3_hold_challenge", challenge_o, 64'h1111_2222_3333_4444);
        end
        resp_ready = 1'b1;
        step();
        check("t3_busy_drop", 64'(busy), 64'(0));
        check("t3_valid_drop", 64'(resp_valid), 64'(0));

        // ---- Mid-run reset during the 5th LAUNCH ----
        start_run(64'h5A5A_5A5A_5A5A_5A5A);
        for (int n = 0; n < 4; n++) run_eval(32'hFFFF_FFFF, -1, 64'h0);
        step();
        step();
        step();
        check("t4_launch_before", 64'(launch_o), 64'(1));
        rst_n = 1'b0;
        step();
        check("t4_launch", 64'(launch_o), 64'(0));
        check("t4_busy", 64'(busy), 64'(0));
        check("t4_valid", 64'(resp_valid), 64'(0));
        check("t4_response", 64'(response_o), 64'(0));
        check("t4_stable", 64'(stable_o), 64'(0));
        check("t4_challenge", challenge_o, 64'h0);
        rst_n = 1'b1;
        step();
        start_run(64'h0F0F_0F0F_F0F0_F0F0);
        for (int n = 0; n < 16; n++) run_eval(32'h1234_5678, -1, 64'h0);
        check("t4_rerun_valid", 64'(resp_valid), 64'(1));
        check("t4_rerun_response", 64'(response_o), 64'h1234_5678);
        check("t4_rerun_stable", 64'(stable_o), 64'hFFFF_FFFF);
        check("t4_rerun_challenge", challenge_o, 64'h0F0F_0F0F_F0F0_F0F0);
        step();

        // ---- Minimum configuration ----
        m_challenge_i = 64'h0000_0000_0000_00C3;
        m_start       = 1'b1;
        step();
        m_start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            check("min_launch", 64'(m_launch_o), 64'(k <= 4));
            check("min_valid_low", 64'(m_resp_valid), 64'(0));
            step();
        end
        check("min_valid", 64'(m_resp_valid), 64'(1));
        check("min_response", 64'(m_response_o), 64'h0000_A5A5);
        check("min_stable", 64'(m_stable_o), 64'hFFFF_FFFF);
        check("min_challenge", m_challenge_o, 64'h0000_0000_0000_00C3);
        step();
        check("min_busy_drop", 64'(m_busy), 64'(0));

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
